// File: rtl/fb_ram_pkg.sv
// rtl/fb_ram_pkg.sv - shared clear-FSM state type and read-latency constants for fb_ram_2p
package fb_ram_pkg;

   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_e;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic bit rd_lat_legal(input int lat);
      return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/fb_ram_clr_seq.sv
// rtl/fb_ram_clr_seq.sv - whole-memory clear sequencer: walks addresses 0..DEPTH-1 one per cycle
module fb_ram_clr_seq
   import fb_ram_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ADDRW = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic             clr_we,
   output logic [ADDRW-1:0] clr_addr,
   output logic             clr_done
);

   localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

   clr_state_e       state_q, state_d;
   logic [ADDRW-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         CLR_IDLE: begin
            if (clr_req) begin
               state_d = CLR_RUN;
               cnt_d   = '0;
            end
         end
         CLR_RUN: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = CLR_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = CLR_IDLE;
      endcase
   end

   // A reset edge aborts the clear without writing the word it would have written.
   assign clr_busy = (state_q == CLR_RUN);
   assign clr_we   = clr_busy && !reset;
   assign clr_addr = cnt_q;
   assign clr_done = done_q;

endmodule

// File: rtl/fb_ram_2p.sv
// rtl/fb_ram_2p.sv - simple dual-port frame buffer RAM with clear sequencer and 1/2-cycle read latency
// FB_RAM_2P_BYPASS_EN: when defined, same-cycle same-address writes are forwarded to the read (write-first).
module fb_ram_2p
   import fb_ram_pkg::*;
#(
   parameter int                WIDTH   = 12,
   parameter int                DEPTH   = 640*480,
   parameter string             INIT_F  = "",
   parameter int                RD_LAT  = 1,
   parameter logic [WIDTH-1:0]  CLR_VAL = '0,
   localparam int               ADDRW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wren,
   input  logic [ADDRW-1:0] wraddress,
   input  logic [WIDTH-1:0] data,
   output logic             wr_ready,
   input  logic             rden,
   input  logic [ADDRW-1:0] rdaddress,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             clr_req,
   output logic             clr_busy,
   output logic             clr_done
);

   localparam logic [ADDRW:0] DEPTH_X = (ADDRW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             clr_we;
   logic [ADDRW-1:0] clr_addr;

   fb_ram_clr_seq #(
      .DEPTH (DEPTH),
      .ADDRW (ADDRW)
   ) u_clr_seq (
      .clock    (clock),
      .reset    (reset),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .clr_done (clr_done)
   );

   assign wr_ready = !clr_busy;

   logic             wr_in_range, rd_in_range;
   logic             mem_we;
   logic [ADDRW-1:0] mem_wa;
   logic [WIDTH-1:0] mem_wd;
   logic [WIDTH-1:0] rd_word;

   assign wr_in_range = ({1'b0, wraddress} < DEPTH_X);
   assign rd_in_range = ({1'b0, rdaddress} < DEPTH_X);

   // The clear sequencer owns the write port while busy; external writes are dropped then.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wraddress;
      mem_wd = data;
      if (clr_busy) begin
         mem_we = clr_we;
         mem_wa = clr_addr;
         mem_wd = CLR_VAL;
      end else begin
         mem_we = wren && wr_in_range && !reset;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem_q[rdaddress];
      end
`ifdef FB_RAM_2P_BYPASS_EN
      if (mem_we && (mem_wa == rdaddress)) begin
         rd_word = mem_wd;
      end
`endif
   end

   logic             lat_valid;
   logic [WIDTH-1:0] lat_data;

   if (RD_LAT == RD_LAT_MAX) begin : g_lat2
      logic             s1_valid_q, s1_valid_d;
      logic [WIDTH-1:0] s1_data_q, s1_data_d;

      always_comb begin
         s1_valid_d = rden;
         s1_data_d  = rd_word;
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
         end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
         end
      end

      assign lat_valid = s1_valid_q;
      assign lat_data  = s1_data_q;
   end else begin : g_lat1
      assign lat_valid = rden;
      assign lat_data  = rd_word;
   end

   logic             q_valid_q, q_valid_d;
   logic [WIDTH-1:0] q_q, q_d;

   // Output register only loads on a completing read, so q holds between reads.
   always_comb begin
      q_valid_d = lat_valid;
      q_d       = q_q;
      if (lat_valid) begin
         q_d = lat_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_valid_q <= 1'b0;
         q_q       <= '0;
      end else begin
         q_valid_q <= q_valid_d;
         q_q       <= q_d;
      end
   end

   assign q       = q_q;
   assign q_valid = q_valid_q;

endmodule

// File: doc/fb_ram_2p.md
FB_RAM_2P -- requirements
Module: fb_ram_2p

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 640*480, number of words; ADDRW = $clog2(DEPTH).
REQ-003 SHALL have parameter INIT_F, default "", hex init file; empty means no load.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter CLR_VAL, default 0, WIDTH-bit word written by the clear sequencer.
REQ-006 SHALL have port clock  in  1  single clock for all logic.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port wren  in  1  write request.
REQ-009 SHALL have port wraddress  in  ADDRW  write address.
REQ-010 SHALL have port data  in  WIDTH  write data.
REQ-011 SHALL have port wr_ready  out  1  high when external writes are accepted.
REQ-012 SHALL have port rden  in  1  read request.
REQ-013 SHALL have port rdaddress  in  ADDRW  read address.
REQ-014 SHALL have port q  out  WIDTH  read data.
REQ-015 SHALL have port q_valid  out  1  q holds the data for a request issued RD_LAT cycles earlier.
REQ-016 SHALL have port clr_req  in  1  start a whole-memory clear.
REQ-017 SHALL have port clr_busy  out  1  clear in progress.
REQ-018 SHALL have port clr_done  out  1  one-cycle pulse when a clear completes.

Function
REQ-019 Write SHALL occur at the clock edge where wren && wr_ready && wraddress < DEPTH; writes to addresses >= DEPTH SHALL be dropped.
REQ-020 Read issued with rden at edge N SHALL present q and q_valid=1 after edge N+RD_LAT-1 (visible from cycle N+RD_LAT); q_valid SHALL be 0 otherwise.
REQ-021 Read of an address >= DEPTH SHALL return q=0 with q_valid=1.
REQ-022 Without rden, q SHALL hold its last value.
REQ-023 Read and write to the same address in the same cycle SHALL return old data (read-first), unless REQ-034 applies.
REQ-024 Clear FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after writing address DEPTH-1.
REQ-025 In CLEAR, one word per cycle SHALL be written with CLR_VAL, from address 0 ascending; a clear SHALL take exactly DEPTH cycles.
REQ-026 clr_busy SHALL equal (state==CLEAR); wr_ready SHALL equal !clr_busy; external writes during CLEAR SHALL be dropped.
REQ-027 clr_done SHALL pulse for one cycle on the cycle after the last clear write; clr_busy SHALL be 0 in that cycle.
REQ-028 clr_req while in CLEAR SHALL be ignored (no restart); clr_req held high SHALL restart a clear from IDLE on the clr_done cycle.
REQ-029 Reads during CLEAR SHALL be served normally and return current, possibly partly cleared, contents.

Reset
REQ-030 On reset: state=IDLE, clear counter=0, q=0, q_valid=0, read pipeline flushed, clr_busy=0, clr_done=0, wr_ready=1.
REQ-031 Reset SHALL NOT alter memory contents; reset mid-clear SHALL abort the clear with no clr_done, leaving addresses already written holding CLR_VAL.
REQ-032 INIT_F, if non-empty, SHALL load only at elaboration, never on reset.

Configuration
REQ-033 Macro FB_RAM_2P_BYPASS_EN SHALL select read-during-write behaviour.
REQ-034 With FB_RAM_2P_BYPASS_EN defined, a same-cycle same-address accepted write (external or clear) SHALL be forwarded to the read (write-first).
REQ-035 Without FB_RAM_2P_BYPASS_EN, REQ-023 read-first behaviour SHALL apply and no bypass logic SHALL exist.

Structure
REQ-036 Package fb_ram_pkg SHALL hold the clear FSM state enum (CLR_IDLE, CLR_RUN) and the RD_LAT legal-value constants.
REQ-037 The clear FSM and address counter SHALL live in sub-module fb_ram_clr_seq; memory array, read pipeline and bypass SHALL stay in fb_ram_2p.

Verification
REQ-038 Write 0xABC to address 5, then read address 5 with RD_LAT=2 -> q=0xABC, q_valid=1 exactly two cycles after rden.
REQ-039 DEPTH=16: pulse clr_req -> clr_busy high 16 cycles, clr_done one pulse, then all addresses read CLR_VAL; wren during clear leaves memory unchanged.
REQ-040 Address 3 holds 0x111; same cycle write 0x222 and read address 3 -> q=0x111 without macro, q=0x222 with FB_RAM_2P_BYPASS_EN.
REQ-041 DEPTH=16: reset asserted on 8th clear cycle -> clr_busy=0, no clr_done, addresses 0-6 hold CLR_VAL, addresses 8-15 unchanged.
REQ-042 DEPTH=12: write 0x7FF to address 13, read address 13 -> q=0, q_valid=1; addresses 0-11 unchanged.
